// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types and helpers for the multi-channel clock generator.
//   DIV_W     : width of the divide / high-time / phase fields (shared by all files)
//   div_t     : one divide/high/phase field
//   ch_cfg_t  : channel configuration {div, high, phase}
//   ch_state_e: per-channel IDLE/RUN state
//   clamp_cfg : raw configuration -> effective configuration
//   reload_val: counter start value that realises the phase offset
package clkgen_pkg;

  localparam int DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  typedef struct packed {
    div_t div;
    div_t high;
    div_t phase;
  } ch_cfg_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // A divide below 2 cannot toggle, so it is raised to 2. A phase outside
  // the period is ignored, and a high time longer than the period saturates
  // so that the output is held high.
  function automatic ch_cfg_t clamp_cfg(input ch_cfg_t raw);
    ch_cfg_t eff;
    eff.div   = (raw.div < div_t'(2'd2)) ? div_t'(2'd2) : raw.div;
    eff.phase = (raw.phase < eff.div) ? raw.phase : {DIV_W{1'b0}};
    eff.high  = (raw.high > eff.div) ? eff.div : raw.high;
    return eff;
  endfunction

  // (div - phase) mod div. Because phase < div, the subtraction lands in
  // 1..div, and it equals div only when phase is zero.
  function automatic div_t reload_val(input ch_cfg_t eff);
    div_t r;
    if (eff.phase == {DIV_W{1'b0}}) begin
      r = {DIV_W{1'b0}};
    end else begin
      r = eff.div - eff.phase;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_gen_ch.sv
// clk_gen_ch: one divided-clock channel with a period counter, a shadow
// config register with its pending flag, IDLE/RUN control and a registered
// output.
//   clk, rst_n : system clock and asynchronous active-low reset
//   i_en       : run enable (IDLE when low)
//   i_wr       : accepted config write for this channel
//   i_wr_cfg   : raw config captured on i_wr
//   o_pending  : a shadow config is waiting to be applied
//   o_apply    : the shadow is applied at this clock edge
//   o_clk      : generated clock, registered
module clk_gen_ch
  import clkgen_pkg::*;
#(
  parameter int DEF_DIV = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_en,
  input  logic    i_wr,
  input  ch_cfg_t i_wr_cfg,
  output logic    o_pending,
  output logic    o_apply,
  output logic    o_clk
);

  localparam ch_cfg_t RST_RAW = '{div:   div_t'(DEF_DIV),
                                  high:  div_t'(DEF_DIV / 2),
                                  phase: {DIV_W{1'b0}}};
  localparam ch_cfg_t RST_CFG = clamp_cfg(RST_RAW);

  ch_state_e r_state;
  ch_state_e w_state_nxt;
  div_t      r_cnt;
  div_t      w_cnt_nxt;
  ch_cfg_t   r_cfg;
  ch_cfg_t   w_cfg_nxt;
  ch_cfg_t   r_shadow;
  ch_cfg_t   w_shadow_eff;
  logic      r_pending;
  logic      r_clk;
  logic      w_clk_nxt;
  logic      w_apply;
  logic      w_eop;

  // Next state, counter, output and config. A new config only takes
  // effect on the last count of a running period or while idle, so an
  // output period is never built from two different settings.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cfg_nxt    = r_cfg;
    w_clk_nxt    = 1'b0;
    w_apply      = 1'b0;
    w_eop        = (r_cnt == (r_cfg.div - div_t'(1'b1)));
    w_shadow_eff = clamp_cfg(r_shadow);
    case (r_state)
      CH_IDLE: begin
        w_apply   = r_pending;
        w_cnt_nxt = reload_val(r_cfg);
        if (i_en) begin
          w_state_nxt = CH_RUN;
        end else begin
          w_state_nxt = CH_IDLE;
        end
      end
      CH_RUN: begin
        w_apply = r_pending & w_eop;
        if (i_en) begin
          w_state_nxt = CH_RUN;
          w_clk_nxt   = (r_cnt < r_cfg.high);
          if (w_eop) begin
            w_cnt_nxt = {DIV_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + div_t'(1'b1);
          end
        end else begin
          // A disable cuts the output immediately, so a high pulse may be shortened.
          w_state_nxt = CH_IDLE;
          w_cnt_nxt   = reload_val(r_cfg);
        end
      end
      default: begin
        w_state_nxt = CH_IDLE;
        w_cnt_nxt   = reload_val(r_cfg);
      end
    endcase
    if (w_apply) begin
      w_cfg_nxt = w_shadow_eff;
      w_cnt_nxt = reload_val(w_shadow_eff);
    end else begin
      w_cfg_nxt = r_cfg;
    end
  end

  // State, counter, active config and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_cnt   <= {DIV_W{1'b0}};
      r_cfg   <= RST_CFG;
      r_clk   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cfg   <= w_cfg_nxt;
      r_clk   <= w_clk_nxt;
    end
  end

  // Shadow register and pending flag. The top only issues a write while
  // pending is clear, so a write and an apply never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '{div: {DIV_W{1'b0}}, high: {DIV_W{1'b0}}, phase: {DIV_W{1'b0}}};
      r_pending <= 1'b0;
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end else if (i_wr) begin
      r_shadow  <= i_wr_cfg;
      r_pending <= 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_apply   = w_apply;
  assign o_clk     = r_clk;

endmodule

// File: rtl/multi_clk_gen.sv
// multi_clk_gen: runtime-programmable multi-channel clock divider.
// The field width DIV_W is defined in clkgen_pkg.
//   clk, rst_n        : system clock and asynchronous active-low reset
//   ch_en[NUM_CH]     : per-channel run enable
//   cfg_valid/ready   : config write handshake. ready = target channel not pending
//   cfg_ch            : target channel
//   cfg_div/high/phase: period, high time and rising-edge delay in clk cycles
//   clk_out[NUM_CH]   : generated clocks, registered
//   locked            : every channel has run on stable settings for LOCK_CYCLES cycles
module multi_clk_gen
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DEF_DIV     = 4,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int LK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_CYCLES);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_clk;
  logic [NUM_CH-1:0] w_pend_nxt;
  logic [NUM_CH-1:0] r_en_q;
  logic [LK_W-1:0]   r_lock_cnt;
  logic [LK_W-1:0]   w_lock_nxt;
  logic              r_locked;
  logic              w_ready;
  logic              w_event;
  ch_cfg_t           w_cfg_in;

  assign w_cfg_in = '{div: cfg_div, high: cfg_high, phase: cfg_phase};

  // Ready mux on the target channel. A channel index beyond NUM_CH is never ready.
  always_comb begin
    w_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ready = (cfg_ch == CH_W'(i)) ? ~w_pending[i] : w_ready;
    end
  end

  // Decode accepted writes to per-channel strobes.
  always_comb begin
    w_wr = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i] = cfg_valid & w_ready & (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_gen_ch #(
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (ch_en[g]),
      .i_wr      (w_wr[g]),
      .i_wr_cfg  (w_cfg_in),
      .o_pending (w_pending[g]),
      .o_apply   (w_apply[g]),
      .o_clk     (w_clk[g])
    );
  end

  // Lock counter next value. An applied config or any enable edge restarts
  // it. Writes that are still pending leave it running, but they hold locked low.
  always_comb begin
    w_event    = (|w_apply) | (ch_en != r_en_q);
    w_pend_nxt = (w_pending | w_wr) & ~w_apply;
    if (w_event) begin
      w_lock_nxt = {LK_W{1'b0}};
    end else if (r_lock_cnt == LK_MAX) begin
      w_lock_nxt = r_lock_cnt;
    end else begin
      w_lock_nxt = r_lock_cnt + LK_W'(1'b1);
    end
  end

  // Lock counter, enable history and registered locked flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_q     <= {NUM_CH{1'b0}};
      r_lock_cnt <= {LK_W{1'b0}};
      r_locked   <= 1'b0;
    end else begin
      r_en_q     <= ch_en;
      r_lock_cnt <= w_lock_nxt;
      r_locked   <= (w_lock_nxt == LK_MAX) & ~(|w_pend_nxt);
    end
  end

  assign cfg_ready = w_ready;
  assign clk_out   = w_clk;
  assign locked    = r_locked;

endmodule

// File: tb/tb_multi_clk_gen.sv
// tb_multi_clk_gen: scoreboard bench for multi_clk_gen with default parameters.
// A time-based reference model predicts clk_out and locked for each edge.
module tb_multi_clk_gen;

  localparam int LOCK = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] ch_en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic [7:0] cfg_phase;
  logic [3:0] clk_out;
  logic       locked;

  multi_clk_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] clk;
    logic       lk;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_fail;

  // Model state. Channel c, while running, outputs
  // ((n - seg) + div - phase) % div < high at edge n.
  int         m_div[4];
  int         m_high[4];
  int         m_phase[4];
  int         m_seg[4];
  bit         m_run[4];
  int         sh_div[4];
  int         sh_high[4];
  int         sh_phase[4];
  logic [3:0] m_pend;
  logic [3:0] m_en_prev;
  int         m_lock;
  int         m_n;
  bit         m_accept;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_div[c]   = 4;
      m_high[c]  = 2;
      m_phase[c] = 0;
      m_seg[c]   = 0;
      m_run[c]   = 1'b0;
    end
    m_pend    = 4'h0;
    m_en_prev = 4'h0;
    m_lock    = 0;
    m_n       = 0;
    m_accept  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge(output exp_t e);
    int pos;
    int d;
    bit ap;
    bit any_ap;
    bit acc;
    acc    = cfg_valid && !m_pend[cfg_ch];
    any_ap = 1'b0;
    e.clk  = 4'h0;
    for (int c = 0; c < 4; c++) begin
      ap = 1'b0;
      if (m_run[c]) begin
        pos = ((m_n - m_seg[c]) + m_div[c] - m_phase[c]) % m_div[c];
        if (ch_en[c]) e.clk[c] = (pos < m_high[c]);
        if (m_pend[c] && pos == m_div[c] - 1) ap = 1'b1;
        if (ap) m_seg[c] = m_n + 1;
        if (!ch_en[c]) m_run[c] = 1'b0;
      end else begin
        if (m_pend[c]) ap = 1'b1;
        if (ch_en[c]) begin
          m_run[c] = 1'b1;
          m_seg[c] = m_n + 1;
        end
      end
      if (ap) begin
        d          = (sh_div[c] < 2) ? 2 : sh_div[c];
        m_div[c]   = d;
        m_phase[c] = (sh_phase[c] < d) ? sh_phase[c] : 0;
        m_high[c]  = (sh_high[c] > d) ? d : sh_high[c];
        m_pend[c]  = 1'b0;
        any_ap     = 1'b1;
      end
    end
    if (acc) begin
      sh_div[cfg_ch]   = int'(cfg_div);
      sh_high[cfg_ch]  = int'(cfg_high);
      sh_phase[cfg_ch] = int'(cfg_phase);
      m_pend[cfg_ch]   = 1'b1;
    end
    m_accept = acc;
    if (any_ap || (ch_en != m_en_prev)) m_lock = 0;
    else if (m_lock < LOCK) m_lock = m_lock + 1;
    m_en_prev = ch_en;
    e.lk      = (m_lock == LOCK) && (m_pend == 4'h0);
    m_n++;
  endtask

  // One clock: check ready, push the prediction, then pop and compare after the edge.
  task automatic tick();
    exp_t e;
    exp_t g;
    #1;
    chk_eq("cfg_ready", {31'd0, cfg_ready}, {31'd0, ~m_pend[cfg_ch]});
    model_edge(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk_eq("clk_out", {28'd0, clk_out}, {28'd0, g.clk});
    chk_eq("locked", {31'd0, locked}, {31'd0, g.lk});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int ch, input int d, input int h, input int p);
    cfg_ch    = ch[1:0];
    cfg_div   = d[7:0];
    cfg_high  = h[7:0];
    cfg_phase = p[7:0];
  endtask

  // Present a write for a single cycle; it may be refused.
  task automatic write_pulse(input int ch, input int d, input int h, input int p);
    set_cfg(ch, d, h, p);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Hold a write until it is accepted, with a bounded wait.
  task automatic write_hold(input int ch, input int d, input int h, input int p);
    bit done;
    done = 1'b0;
    set_cfg(ch, d, h, p);
    cfg_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      tick();
      done = m_accept;
    end
    cfg_valid = 1'b0;
    chk_eq("wr_accept", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int lk_at;
    int hi_at;
    bit seen;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    ch_en     = 4'h0;
    cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0);
    model_reset();

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    #3;
    chk_eq("rst_clk_out", {28'd0, clk_out}, 32'd0);
    chk_eq("rst_locked", {31'd0, locked}, 32'd0);
    chk_eq("rst_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    ticks(3);

    // Enable all channels on the default settings and time the lock.
    ch_en = 4'hF;
    lk_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (locked === 1'b1 && lk_at < 0) lk_at = i;
    end
    chk_eq("lock_delay", lk_at - 1, 32'd16);

    // Reconfigure ch1 while it runs.
    write_pulse(1, 10, 3, 4);
    ticks(40);

    // Back-to-back writes to ch2, with a ch3 write in between.
    write_pulse(2, 6, 2, 1);
    write_pulse(2, 8, 4, 0);
    write_pulse(3, 3, 1, 0);
    write_hold(2, 8, 4, 0);
    ticks(30);

    // Edge-case settings.
    write_hold(0, 0, 1, 0);
    write_hold(1, 1, 1, 0);
    write_hold(2, 5, 0, 0);
    write_hold(3, 5, 9, 0);
    ticks(24);
    write_hold(0, 5, 2, 7);
    ticks(24);

    // Disable ch0 during a high pulse, then re-enable it with a phase offset.
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      tick();
      seen = (clk_out[0] === 1'b1);
    end
    chk_eq("ch0_high_seen", {31'd0, seen}, 32'd1);
    ch_en[0] = 1'b0;
    tick();
    write_hold(0, 6, 3, 2);
    ticks(3);
    ch_en[0] = 1'b1;
    hi_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (clk_out[0] === 1'b1 && hi_at < 0) hi_at = i;
    end
    chk_eq("ch0_first_high", hi_at - 1, 32'd3);

    // Pulse reset with a write still pending on ch0.
    write_pulse(0, 12, 6, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_clk_out", {28'd0, clk_out}, 32'd0);
    chk_eq("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk_eq("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
    ticks(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
